// File: rtl/bc_buffer_pkg.sv
// ---------------------------------------------------------------------------
// bc_buffer_pkg
// Shared widths and types for the bit-count (BC) FIFO between the control
// block and the obstacle-avoidance block.
//   BC_WIDTH  : width of one BC word
//   BC_DEPTH  : number of words the FIFO holds (power of two)
//   bc_word_t : one BC word
//   ptrWidth  : pointer width for a given depth (index bits plus a wrap bit)
// ---------------------------------------------------------------------------
package bc_buffer_pkg;

  localparam int BC_WIDTH = 16;
  localparam int BC_DEPTH = 16;

  typedef logic [BC_WIDTH-1:0] bc_word_t;

  // The extra top bit tells a full FIFO apart from an empty one when the
  // index bits of both pointers coincide.
  function automatic int ptrWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/bc_sync_fifo.sv
// ---------------------------------------------------------------------------
// bc_sync_fifo
// Single-clock FIFO storage with a registered read port.
// Ports:
//   clk        : system clock, rising edge
//   rst        : asynchronous active-high reset (pointers and read data)
//   wrEn_i     : push wrData_i this cycle
//   wrData_i   : word to push
//   rdEn_i     : pop the head word this cycle
//   rdData_o   : registered head word, updated only on a successful pop
//   wrDone_o   : the push requested this cycle is accepted
//   rdDone_o   : the pop requested this cycle is accepted
// ---------------------------------------------------------------------------
module bc_sync_fifo
  import bc_buffer_pkg::*;
#(
  parameter int WIDTH = BC_WIDTH,
  parameter int DEPTH = BC_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wrEn_i,
  input  logic [WIDTH-1:0] wrData_i,
  input  logic             rdEn_i,
  output logic [WIDTH-1:0] rdData_o,
  output logic             wrDone_o,
  output logic             rdDone_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptrWidth(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0]    wrPtr_q, wrPtr_d;
  logic [PW-1:0]    rdPtr_q, rdPtr_d;
  logic [WIDTH-1:0] rdData_q, rdData_d;

  logic             empty;
  logic             full;
  logic             rdDo;
  logic             wrDo;

  // Equal pointers mean empty; equal indices with opposite wrap bits mean
  // the writer has lapped the reader exactly once, i.e. full.
  assign empty = (wrPtr_q == rdPtr_q);
  assign full  = (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]) &&
                 (wrPtr_q[AW] != rdPtr_q[AW]);

  // A pop on a full FIFO frees the slot the simultaneous push lands in, so
  // the push is allowed. A push into an empty FIFO is not bypassed to the
  // read port, so a simultaneous pop there is simply refused.
  assign rdDo = rdEn_i && !empty;
  assign wrDo = wrEn_i && (!full || rdDo);

  // Pointer and read-data next state.
  always_comb begin
    wrPtr_d  = wrPtr_q;
    rdPtr_d  = rdPtr_q;
    rdData_d = rdData_q;
    if (wrDo) begin
      wrPtr_d = wrPtr_q + PW'(1);
    end
    if (rdDo) begin
      rdPtr_d  = rdPtr_q + PW'(1);
      rdData_d = mem[rdPtr_q[AW-1:0]];
    end
  end

  // Pointers and read data are cleared by reset, discarding stored words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
      rdData_q <= '0;
    end else begin
      wrPtr_q  <= wrPtr_d;
      rdPtr_q  <= rdPtr_d;
      rdData_q <= rdData_d;
    end
  end

  // Storage array has no reset; only the pointers define which words are valid.
  always_ff @(posedge clk) begin
    if (wrDo) begin
      mem[wrPtr_q[AW-1:0]] <= wrData_i;
    end
  end

  assign rdData_o = rdData_q;
  assign wrDone_o = wrDo;
  assign rdDone_o = rdDo;

endmodule

// File: rtl/bc_fifo_buffer.sv
// ---------------------------------------------------------------------------
// bc_fifo_buffer
// BC word FIFO from the control block to the avoidance block, plus one-cycle
// handoff strobes to the serializer/deserializer paced by the serial clock.
// Ports:
//   clk        : system clock, rising edge
//   rst        : asynchronous active-high reset
//   sck        : serial-link clock, asynchronous to clk, sampled only
//   ctrl_rdy   : push bc_in this cycle
//   avoid_rdy  : pop the head word this cycle
//   from_avoid : link direction, 0 = serialize, 1 = deserialize
//   bc_in      : word to push
//   bc_out     : registered head word
//   start_ser  : one-cycle strobe, a popped word is ready for the serializer
//   start_des  : one-cycle strobe, a written word was taken from the deserializer
// ---------------------------------------------------------------------------
module bc_fifo_buffer
  import bc_buffer_pkg::*;
#(
  parameter int WIDTH = BC_WIDTH,
  parameter int DEPTH = BC_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sck,
  input  logic             ctrl_rdy,
  input  logic             avoid_rdy,
  input  logic             from_avoid,
  input  logic [WIDTH-1:0] bc_in,
  output logic [WIDTH-1:0] bc_out,
  output logic             start_ser,
  output logic             start_des
);

  logic wrDone;
  logic rdDone;

  logic sckMeta_q;
  logic sckSync_q;
  logic sckPrev_q;
  logic sckRise;

  logic serPending_q, serPending_d;
  logic desPending_q, desPending_d;
  logic startSer_q, startSer_d;
  logic startDes_q, startDes_d;

  bc_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wrEn_i   (ctrl_rdy),
    .wrData_i (bc_in),
    .rdEn_i   (avoid_rdy),
    .rdData_o (bc_out),
    .wrDone_o (wrDone),
    .rdDone_o (rdDone)
  );

  // Two flops bring sck into the clk domain; the third remembers the
  // previous synchronized level for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sckMeta_q <= 1'b0;
      sckSync_q <= 1'b0;
      sckPrev_q <= 1'b0;
    end else begin
      sckMeta_q <= sck;
      sckSync_q <= sckMeta_q;
      sckPrev_q <= sckSync_q;
    end
  end

  assign sckRise = sckSync_q && !sckPrev_q;

  // A pending flag only fires from its registered value, so an sck rise in
  // the same cycle as the event cannot release it; it waits for the next
  // rise. Events arriving while a flag is already pending fold into it.
  always_comb begin
    serPending_d = (serPending_q && !sckRise) || (rdDone && !from_avoid);
    desPending_d = (desPending_q && !sckRise) || (wrDone && from_avoid);
    startSer_d   = serPending_q && sckRise;
    startDes_d   = desPending_q && sckRise;
  end

  // Pending flags and registered strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      serPending_q <= 1'b0;
      desPending_q <= 1'b0;
      startSer_q   <= 1'b0;
      startDes_q   <= 1'b0;
    end else begin
      serPending_q <= serPending_d;
      desPending_q <= desPending_d;
      startSer_q   <= startSer_d;
      startDes_q   <= startDes_d;
    end
  end

  assign start_ser = startSer_q;
  assign start_des = startDes_q;

endmodule

// File: tb/tb_bc_fifo_buffer.sv
// ---------------------------------------------------------------------------
// tb_bc_fifo_buffer
// Self-checking bench for bc_fifo_buffer: directed fill/drain, full, wrap,
// empty-simultaneous and strobe scenarios plus a randomized phase, all
// compared against a queue-based reference of the FIFO behaviour.
// ---------------------------------------------------------------------------
module tb_bc_fifo_buffer;

  logic        clk;
  logic        rst;
  logic        sck;
  logic        ctrlRdy;
  logic        avoidRdy;
  logic        fromAvoid;
  logic [15:0] bcIn;
  logic [15:0] bcOut;
  logic        startSer;
  logic        startDes;

  int checkCount;
  int errorCount;

  logic [15:0] modelQ[$];
  logic [15:0] modelOut;

  bc_fifo_buffer #(
    .WIDTH (16),
    .DEPTH (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sck        (sck),
    .ctrl_rdy   (ctrlRdy),
    .avoid_rdy  (avoidRdy),
    .from_avoid (fromAvoid),
    .bc_in      (bcIn),
    .bc_out     (bcOut),
    .start_ser  (startSer),
    .start_des  (startDes)
  );

  // Free-running system clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Drives one cycle of inputs, lets the edge happen, advances the reference
  // FIFO by the same request and compares the read port just after the edge.
  task automatic applyStimulus(input logic wr, input logic rd, input logic fa,
                               input logic [15:0] d);
    bit doRd;
    bit doWr;
    ctrlRdy   = wr;
    avoidRdy  = rd;
    fromAvoid = fa;
    bcIn      = d;
    @(posedge clk);
    #1;
    doRd = rd && (modelQ.size() != 0);
    doWr = wr && ((modelQ.size() < 16) || doRd);
    if (doRd) modelOut = modelQ.pop_front();
    if (doWr) modelQ.push_back(d);
    checkOutput("bcOut", {16'd0, bcOut}, {16'd0, modelOut});
    ctrlRdy  = 1'b0;
    avoidRdy = 1'b0;
  endtask

  // Asserts reset in the middle of a cycle and checks its effect before any edge.
  task automatic doReset();
    rst = 1'b1;
    sck = 1'b0;
    #2;
    checkOutput("rstBcOut", {16'd0, bcOut}, 32'd0);
    checkOutput("rstSer", {31'd0, startSer}, 32'd0);
    checkOutput("rstDes", {31'd0, startDes}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelQ.delete();
    modelOut = '0;
  endtask

  // Runs a strobe scenario: sck toggles every 4 clk cycles; the expected
  // strobe fires exactly once, 3-4 edges after sck first goes high.
  task automatic runStrobeWindow(input bit expectSer);
    int serPulses;
    int desPulses;
    int pulseAt;
    int riseAt;
    serPulses = 0;
    desPulses = 0;
    pulseAt   = -1;
    riseAt    = 4;
    for (int i = 0; i < 40; i++) begin
      sck = ((i / 4) % 2) == 1;
      applyStimulus(1'b0, 1'b0, 1'b0, 16'd0);
      if (startSer) begin
        serPulses++;
        if (expectSer) pulseAt = i;
      end
      if (startDes) begin
        desPulses++;
        if (!expectSer) pulseAt = i;
      end
    end
    sck = 1'b0;
    checkOutput(expectSer ? "serCount" : "serCountQuiet", serPulses, expectSer ? 1 : 0);
    checkOutput(expectSer ? "desCountQuiet" : "desCount", desPulses, expectSer ? 0 : 1);
    checkOutput("strobeLatency",
                {31'd0, ((pulseAt - riseAt + 1) >= 3) && ((pulseAt - riseAt + 1) <= 4)},
                32'd1);
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst        = 1'b0;
    sck        = 1'b0;
    ctrlRdy    = 1'b0;
    avoidRdy   = 1'b0;
    fromAvoid  = 1'b0;
    bcIn       = '0;
    modelOut   = '0;

    @(posedge clk);
    #1;
    doReset();

    // Pop on an empty FIFO after reset leaves the read port at zero.
    applyStimulus(1'b0, 1'b1, 1'b0, 16'd0);
    checkOutput("emptyPop", {16'd0, bcOut}, 32'd0);

    // Fill with 10..19, idle two cycles, then drain one word per cycle.
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 1'b0, 16'(10 + i));
    applyStimulus(1'b0, 1'b0, 1'b0, 16'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'd0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 16'd0);
      checkOutput("drainOrder", {16'd0, bcOut}, 32'(10 + i));
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 16'd0);
    checkOutput("drainHold", {16'd0, bcOut}, 32'd19);

    // Reset mid-operation with words resident discards them.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 16'(200 + i));
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b0, 16'd0);
    checkOutput("rstDiscard", {16'd0, bcOut}, 32'd0);

    // Push 17 words into a 16-deep FIFO; the last must be dropped.
    for (int i = 0; i < 17; i++) applyStimulus(1'b1, 1'b0, 1'b0, 16'(i));
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 16'd0);
      if (i < 16) checkOutput("fullOrder", {16'd0, bcOut}, 32'(i));
    end
    checkOutput("fullDrop", {16'd0, bcOut}, 32'd15);

    // Keep 8 words resident and stream push+pop across pointer wrap.
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 1'b0, 16'(100 + i));
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 16'(108 + i));
      checkOutput("wrapOrder", {16'd0, bcOut}, 32'(100 + i));
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 16'd0);
      checkOutput("wrapTail", {16'd0, bcOut}, 32'(140 + i));
    end

    // Push+pop together on an empty FIFO: no bypass, the word waits.
    applyStimulus(1'b1, 1'b0, 1'b0, 16'd55);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'd77);
    checkOutput("emptySimHold", {16'd0, bcOut}, 32'd55);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'd0);
    checkOutput("emptySimNext", {16'd0, bcOut}, 32'd77);

    // Serialize strobe after one pop with from_avoid low.
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 16'd5);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'd0);
    runStrobeWindow(1'b1);

    // Deserialize strobe after one write with from_avoid high.
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b1, 16'd6);
    runStrobeWindow(1'b0);

    // Randomized traffic with sck held low: strobes must never fire.
    doReset();
    for (int i = 0; i < 400; i++) begin
      logic wr;
      logic rd;
      if (i < 200) begin
        wr = ($urandom_range(0, 3) != 0);
        rd = ($urandom_range(0, 3) == 0);
      end else begin
        wr = ($urandom_range(0, 3) == 0);
        rd = ($urandom_range(0, 3) != 0);
      end
      applyStimulus(wr, rd, 1'($urandom_range(0, 1)), 16'($urandom));
      checkOutput("randSer", {31'd0, startSer}, 32'd0);
      checkOutput("randDes", {31'd0, startDes}, 32'd0);
    end
    while (modelQ.size() != 0) applyStimulus(1'b0, 1'b1, 1'b0, 16'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
